// File: rtl/alu_writeback.sv
// alu_writeback: execute/writeback stage behind the combinational ALU.
//   Captures ALU results on the exec1 strobe and drives the register-file
//   write port. Owns the architectural status register and stack pointer.
//   MUL is split into two writes (low word to Rd, high word to Rd+1), and
//   further issue is stalled while the high-word write is pending.
// Ports:
//   clk, reset_n           - rising-edge clock, async active-low reset
//   exec1                  - execute strobe, sampled on the rising edge
//   encoded_opcode         - decoded opcode of the instruction in execute
//   reg_write_addr         - destination register Rd
//   aluout1 / aluout2      - ALU primary result / secondary (MUL high word)
//   statusregout           - next status value from the ALU
//   decremented_stack_reg  - next stack pointer from the ALU
//   rf_we/rf_waddr/rf_wdata- register-file write port (registered)
//   status_reg, stack_reg  - architectural status register / stack pointer
//   busy                   - MUL high-word write pending; exec1 ignored
//   done                   - pulse when an instruction's final writeback shows
module alu_writeback #(
  parameter int unsigned      DATA_W   = 16,
  parameter int unsigned      SR_W     = 8,
  parameter int unsigned      SP_W     = 12,
  parameter int unsigned      ADDR_W   = 3,
  parameter logic [SP_W-1:0]  SP_RESET = 12'hFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exec1,
  input  logic [5:0]        encoded_opcode,
  input  logic [ADDR_W-1:0] reg_write_addr,
  input  logic [DATA_W-1:0] aluout1,
  input  logic [DATA_W-1:0] aluout2,
  input  logic [SR_W-1:0]   statusregout,
  input  logic [SP_W-1:0]   decremented_stack_reg,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [SR_W-1:0]   status_reg,
  output logic [SP_W-1:0]   stack_reg,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, HI} state_t;
  typedef enum logic [2:0] {CLS_NOP, CLS_WR1, CLS_MUL, CLS_FLAG, CLS_STK} op_class_t;

  state_t            state_q, state_d;
  op_class_t         op_class;
  logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
  logic [DATA_W-1:0] hi_data_q, hi_data_d;

  logic              we_d, done_d, busy_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [SR_W-1:0]   sr_d;
  logic [SP_W-1:0]   sp_d;

  always_comb begin
    op_class = CLS_NOP;
    case (encoded_opcode) inside
      6'h03, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
      6'h11, 6'h12, 6'h13, 6'h14, 6'h17, 6'h1D, 6'h1E, 6'h1F, 6'h22:
        op_class = CLS_WR1;
      6'h21:
        op_class = CLS_MUL;
      6'h15, 6'h16, [6'h29:6'h36]:
        op_class = CLS_FLAG;
      6'h24, 6'h26:
        op_class = CLS_STK;
      default:
        op_class = CLS_NOP;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    waddr_d   = rf_waddr;
    wdata_d   = rf_wdata;
    sr_d      = status_reg;
    sp_d      = stack_reg;

    case (state_q)
      IDLE: begin
        if (exec1) begin
          case (op_class)
            CLS_WR1: begin
              we_d    = 1'b1;
              waddr_d = reg_write_addr;
              wdata_d = aluout1;
              done_d  = 1'b1;
              sr_d    = statusregout;
            end
            CLS_MUL: begin
              we_d      = 1'b1;
              waddr_d   = reg_write_addr;
              wdata_d   = aluout1;
              busy_d    = 1'b1;
              sr_d      = statusregout;
              hi_addr_d = reg_write_addr + ADDR_W'(1);
              hi_data_d = aluout2;
              state_d   = HI;
            end
            CLS_FLAG: begin
              done_d = 1'b1;
              sr_d   = statusregout;
            end
            CLS_STK: begin
              done_d = 1'b1;
              sp_d   = decremented_stack_reg;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      HI: begin
        // exec1 is deliberately not looked at here: the strobe is dropped.
        we_d    = 1'b1;
        waddr_d = hi_addr_q;
        wdata_d = hi_data_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hi_addr_q  <= '0;
      hi_data_q  <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      status_reg <= '0;
      stack_reg  <= SP_RESET;
    end else begin
      state_q    <= state_d;
      hi_addr_q  <= hi_addr_d;
      hi_data_q  <= hi_data_d;
      rf_we      <= we_d;
      rf_waddr   <= waddr_d;
      rf_wdata   <= wdata_d;
      done       <= done_d;
      busy       <= busy_d;
      status_reg <= sr_d;
      stack_reg  <= sp_d;
    end
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute/writeback stage directly downstream of the combinational ALU.
- Captures the ALU results on the exec1 timing strobe and drives the register-file write port.
- Owns the architectural status register and stack pointer, and commits them from the ALU's status and stack outputs.
- Sequences MUL as two register writes: low word to Rd, high word to Rd+1. Stalls further issue while the second write is pending.

Parameters:
DATA_W, 16, datapath width
SR_W, 8, status register width
SP_W, 12, stack pointer width
ADDR_W, 3, register-file address width
SP_RESET, 12'hFFF, stack pointer reset value

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
exec1  in  1  execute strobe; sampled on the rising edge of clk
encoded_opcode  in  6  decoded opcode of the instruction in execute
reg_write_addr  in  ADDR_W  destination register Rd
aluout1  in  DATA_W  ALU primary result (MUL: low word)
aluout2  in  DATA_W  ALU secondary result (MUL: high word)
statusregout  in  SR_W  next status value computed by the ALU
decremented_stack_reg  in  SP_W  next stack pointer computed by the ALU
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
status_reg  out  SR_W  architectural status register; fed back to the ALU statusregin
stack_reg  out  SP_W  architectural stack pointer; fed back to the ALU stack_reg
busy  out  1  high while a MUL high-word write is pending; exec1 is ignored while high
done  out  1  one-cycle pulse in the cycle the instruction's final writeback is presented

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, done=0, busy=0.
  - status_reg=0, stack_reg=SP_RESET.
  - A pending MUL high write is discarded.
- Opcode classes:
  - WR1 (single write): 03,06,07,08,09,0B,0C,0D,0E,11,12,13,14,17,1D,1E,1F,22.
  - MUL (two writes): 21.
  - FLAG (status only, no write): 15,16,29..36.
  - STK (stack only): 24,26.
  - All other opcodes: NOP, no state change except done.
- Status commit: status_reg <= statusregout on the accepting edge for WR1, MUL and FLAG classes; otherwise held.
- Stack commit: stack_reg <= decremented_stack_reg on the accepting edge for STK only. Underflow wrap comes from the ALU; this block stores it unchanged.
- Accept = exec1=1 && state==IDLE at a rising edge (edge N). All outputs are registered; latency is one cycle.
- IDLE accepting WR1:
  - Cycle N+1: rf_we=1, rf_waddr=reg_write_addr, rf_wdata=aluout1, done=1.
  - State stays IDLE.
- IDLE accepting MUL:
  - Cycle N+1: rf_we=1, rf_waddr=Rd, rf_wdata=aluout1, done=0, busy=1.
  - aluout2 and the address (Rd+1) mod 2^ADDR_W are latched internally; state goes to HI.
- HI, next edge:
  - Cycle N+2: rf_we=1, rf_waddr=latched Rd+1, rf_wdata=latched high word, done=1, busy=0.
  - State returns to IDLE.
  - exec1 asserted while in HI is ignored: no capture, no status or stack change, and it is not queued.
- IDLE accepting FLAG/STK/NOP: cycle N+1 has rf_we=0, done=1.
- No accept: rf_we=0 and done=0 the following cycle. rf_waddr and rf_wdata hold their last values.
- Address wrap: Rd=7 gives the high write to register 0.
- Back-to-back: exec1 high on consecutive edges in IDLE with WR1 ops gives one write per cycle, each with done=1.
- After a MUL, the next accept is possible at the edge that ends cycle N+1? No: the edge ending N+1 occurs in HI and is ignored. The next accept is the edge ending cycle N+2.
- Reset asserted mid-MUL: the high write is not performed; after release the block is in IDLE with rf_we=0.

Test Plan:
- Reset: reset_n=0 asynchronously, mid-cycle -> immediately rf_we=0, status_reg=8'h00, stack_reg=12'hFFF, busy=0.
- ADD: exec1=1, opcode 11, Rd=3, aluout1=16'h1234, statusregout=8'h02 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234, done=1, status_reg=8'h02.
- MUL wrap: opcode 21, Rd=7, aluout1=16'hBEEF, aluout2=16'hDEAD -> cycle N+1: waddr=7, wdata=16'hBEEF, busy=1, done=0. Cycle N+2: waddr=0, wdata=16'hDEAD, done=1, busy=0.
- MUL stall: repeat MUL, hold exec1=1 with opcode 11 during cycle N+1 -> that edge is ignored and status is unchanged. ADD is accepted at the edge ending N+2, and its write appears in N+3.
- CALL then SEC: opcode 24 with decremented_stack_reg=12'hFFE -> stack_reg=12'hFFE, rf_we=0, done=1. Then opcode 2D with statusregout=8'h04 -> status_reg=8'h04, stack_reg held.
- Reset mid-MUL: assert reset_n=0 during cycle N+1 of a MUL -> no write to Rd+1 ever occurs, and state is IDLE after release.
